// File: rtl/insn_byte_encoder_pkg.sv
// Shared types for the instruction byte encoder: FSM states, size codes and
// code-to-byte-count decode helpers (reserved codes decode to their coerced size).
package EncoderTypes;

  localparam int unsigned MAX_INSN_LEN = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REX,
    ST_OPC,
    ST_MODRM,
    ST_SIB,
    ST_DISP,
    ST_IMM
  } state_t;

  typedef enum logic [1:0] {
    DISP_NONE = 2'd0,
    DISP_8    = 2'd1,
    DISP_32   = 2'd2,
    DISP_RSVD = 2'd3
  } disp_code_t;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_8     = 3'd1,
    IMM_16    = 3'd2,
    IMM_32    = 3'd3,
    IMM_64    = 3'd4,
    IMM_RSVD5 = 3'd5,
    IMM_RSVD6 = 3'd6,
    IMM_RSVD7 = 3'd7
  } imm_code_t;

  function automatic logic [1:0] opc_size(input logic [1:0] len);
    return (len == 2'd0) ? 2'd1 : len;
  endfunction

  function automatic logic [2:0] disp_size(input disp_code_t code);
    case (code)
      DISP_NONE: return 3'd0;
      DISP_8:    return 3'd1;
      default:   return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] imm_size(input imm_code_t code);
    case (code)
      IMM_NONE: return 4'd0;
      IMM_8:    return 4'd1;
      IMM_16:   return 4'd2;
      IMM_32:   return 4'd4;
      default:  return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/insn_byte_encoder_len_calc.sv
// Combinational section sizing for an instruction bundle; also flags bundles
// with reserved codes or a total length beyond MAX_LEN.
module enc_len_calc
  import EncoderTypes::*;
#(
  parameter int unsigned MAX_LEN = MAX_INSN_LEN
) (
  input  logic       rex_en,
  input  logic [1:0] opc_len,
  input  logic       has_modrm,
  input  logic       has_sib,
  input  logic [1:0] disp_code,
  input  logic [2:0] imm_code,
  output logic       rex_sz,
  output logic [1:0] opc_sz,
  output logic       modrm_sz,
  output logic       sib_sz,
  output logic [2:0] disp_sz,
  output logic [3:0] imm_sz,
  output logic [4:0] total,
  output logic       illegal
);

  always_comb begin
    rex_sz   = rex_en;
    opc_sz   = opc_size(opc_len);
    modrm_sz = has_modrm;
    sib_sz   = has_modrm & has_sib;
    disp_sz  = disp_size(disp_code_t'(disp_code));
    imm_sz   = imm_size(imm_code_t'(imm_code));
    total    = {4'd0, rex_sz} + {3'd0, opc_sz} + {4'd0, modrm_sz} + {4'd0, sib_sz}
             + {2'd0, disp_sz} + {1'd0, imm_sz};
    illegal  = (opc_len == 2'd0) || (disp_code == 2'd3) || (imm_code >= 3'd5)
            || ({27'd0, total} > MAX_LEN);
  end

endmodule

// File: rtl/insn_byte_encoder.sv
// Serializes a decoded x86-64 instruction bundle into machine-code bytes, one per cycle.
// Optional bundle rejection is enabled by defining INSN_ENCODER_CHECK_EN.
module insn_byte_encoder
  import EncoderTypes::*;
#(
  parameter int unsigned MAX_LEN = MAX_INSN_LEN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        rex_en,
  input  logic [3:0]  rex_wrxb,
  input  logic [1:0]  opc_len,
  input  logic [23:0] opcode,
  input  logic        has_modrm,
  input  logic [7:0]  modrm,
  input  logic        has_sib,
  input  logic [7:0]  sib,
  input  logic [1:0]  disp_code,
  input  logic [31:0] disp,
  input  logic [2:0]  imm_code,
  input  logic [63:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic        err
);

  state_t      state, state_d;
  logic [2:0]  cnt, cnt_d;
  logic        out_valid_d, out_last_d, err_d;
  logic [7:0]  out_byte_d;
  logic        load, step, accept, fire;

  logic        rex_q, modrm_en_q, sib_en_q;
  logic [3:0]  wrxb_q;
  logic [1:0]  opc_sz_q;
  logic [23:0] opcode_q;
  logic [7:0]  modrm_q, sib_q;
  logic [2:0]  disp_sz_q;
  logic [31:0] disp_q;
  logic [3:0]  imm_sz_q;
  logic [63:0] imm_q;

  logic        c_rex, c_modrm, c_sib, c_illegal;
  logic [1:0]  c_opc_sz;
  logic [2:0]  c_disp_sz;
  logic [3:0]  c_imm_sz;
  logic [4:0]  c_total;

  logic        s_rex, s_modrm_en, s_sib_en;
  logic [3:0]  s_wrxb;
  logic [1:0]  s_opc_sz;
  logic [23:0] s_opcode;
  logic [7:0]  s_modrm, s_sib;
  logic [2:0]  s_disp_sz;
  logic [31:0] s_disp;
  logic [3:0]  s_imm_sz;
  logic [63:0] s_imm;

  enc_len_calc #(.MAX_LEN(MAX_LEN)) u_len (
    .rex_en    (rex_en),
    .opc_len   (opc_len),
    .has_modrm (has_modrm),
    .has_sib   (has_sib),
    .disp_code (disp_code),
    .imm_code  (imm_code),
    .rex_sz    (c_rex),
    .opc_sz    (c_opc_sz),
    .modrm_sz  (c_modrm),
    .sib_sz    (c_sib),
    .disp_sz   (c_disp_sz),
    .imm_sz    (c_imm_sz),
    .total     (c_total),
    .illegal   (c_illegal)
  );

  logic unused_calc;
  assign unused_calc = ^{c_total, c_illegal};

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign fire     = out_valid && out_ready;

  function automatic state_t after_sec(input state_t s, input logic rex, input logic modrm_en,
                                       input logic sib_en, input logic [2:0] dsz,
                                       input logic [3:0] isz);
    state_t after_disp, after_sib;
    after_disp = (isz != 4'd0) ? ST_IMM : ST_IDLE;
    after_sib  = (dsz != 3'd0) ? ST_DISP : after_disp;
    case (s)
      ST_IDLE:  return rex ? ST_REX : ST_OPC;
      ST_REX:   return ST_OPC;
      ST_OPC:   return modrm_en ? ST_MODRM : after_sib;
      ST_MODRM: return sib_en ? ST_SIB : after_sib;
      ST_SIB:   return after_sib;
      ST_DISP:  return after_disp;
      default:  return ST_IDLE;
    endcase
  endfunction

  function automatic logic [3:0] sec_size(input state_t s, input logic [1:0] osz,
                                          input logic [2:0] dsz, input logic [3:0] isz);
    case (s)
      ST_REX, ST_MODRM, ST_SIB: return 4'd1;
      ST_OPC:  return {2'd0, osz};
      ST_DISP: return {1'd0, dsz};
      ST_IMM:  return isz;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] sec_byte(input state_t s, input logic [2:0] c,
                                          input logic [3:0] wrxb, input logic [23:0] opc,
                                          input logic [1:0] osz, input logic [7:0] mrm,
                                          input logic [7:0] sb, input logic [31:0] dsp,
                                          input logic [63:0] im);
    logic [1:0]  idx;
    logic [23:0] opc_sh;
    logic [31:0] dsp_sh;
    logic [63:0] im_sh;
    idx    = osz - 2'd1 - c[1:0];
    opc_sh = opc >> {idx, 3'b000};
    dsp_sh = dsp >> {c[1:0], 3'b000};
    im_sh  = im >> {c, 3'b000};
    case (s)
      ST_REX:   return {4'b0100, wrxb};
      ST_OPC:   return opc_sh[7:0];
      ST_MODRM: return mrm;
      ST_SIB:   return sb;
      ST_DISP:  return dsp_sh[7:0];
      ST_IMM:   return im_sh[7:0];
      default:  return 8'h00;
    endcase
  endfunction

  // The first byte is registered on the accept edge itself, so in IDLE the
  // byte/size sources come straight from the inputs instead of the holding regs.
  always_comb begin
    if (state == ST_IDLE) begin
      s_rex = c_rex;  s_wrxb = rex_wrxb;  s_opc_sz = c_opc_sz;  s_opcode = opcode;
      s_modrm_en = c_modrm;  s_modrm = modrm;  s_sib_en = c_sib;  s_sib = sib;
      s_disp_sz = c_disp_sz;  s_disp = disp;  s_imm_sz = c_imm_sz;  s_imm = imm;
    end else begin
      s_rex = rex_q;  s_wrxb = wrxb_q;  s_opc_sz = opc_sz_q;  s_opcode = opcode_q;
      s_modrm_en = modrm_en_q;  s_modrm = modrm_q;  s_sib_en = sib_en_q;  s_sib = sib_q;
      s_disp_sz = disp_sz_q;  s_disp = disp_q;  s_imm_sz = imm_sz_q;  s_imm = imm_q;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    out_valid_d = out_valid;
    out_byte_d  = out_byte;
    out_last_d  = out_last;
    err_d       = 1'b0;
    load        = 1'b0;
    step        = 1'b0;

    if (accept) begin
      load = 1'b1;
`ifdef INSN_ENCODER_CHECK_EN
      if (c_illegal) begin
        err_d = 1'b1;
      end else begin
        state_d = after_sec(ST_IDLE, s_rex, s_modrm_en, s_sib_en, s_disp_sz, s_imm_sz);
        cnt_d   = 3'd0;
        step    = 1'b1;
      end
`else
      state_d = after_sec(ST_IDLE, s_rex, s_modrm_en, s_sib_en, s_disp_sz, s_imm_sz);
      cnt_d   = 3'd0;
      step    = 1'b1;
`endif
    end else if (fire) begin
      step = 1'b1;
      if ({1'b0, cnt} == sec_size(state, s_opc_sz, s_disp_sz, s_imm_sz) - 4'd1) begin
        state_d = after_sec(state, s_rex, s_modrm_en, s_sib_en, s_disp_sz, s_imm_sz);
        cnt_d   = 3'd0;
      end else begin
        cnt_d = cnt + 3'd1;
      end
    end

    if (step) begin
      out_valid_d = (state_d != ST_IDLE);
      out_byte_d  = sec_byte(state_d, cnt_d, s_wrxb, s_opcode, s_opc_sz, s_modrm, s_sib,
                             s_disp, s_imm);
      out_last_d  = (state_d != ST_IDLE)
                 && (after_sec(state_d, s_rex, s_modrm_en, s_sib_en, s_disp_sz, s_imm_sz) == ST_IDLE)
                 && ({1'b0, cnt_d} == sec_size(state_d, s_opc_sz, s_disp_sz, s_imm_sz) - 4'd1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_byte   <= '0;
      out_last   <= 1'b0;
      err        <= 1'b0;
      rex_q      <= 1'b0;
      wrxb_q     <= '0;
      opc_sz_q   <= '0;
      opcode_q   <= '0;
      modrm_en_q <= 1'b0;
      modrm_q    <= '0;
      sib_en_q   <= 1'b0;
      sib_q      <= '0;
      disp_sz_q  <= '0;
      disp_q     <= '0;
      imm_sz_q   <= '0;
      imm_q      <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      out_valid <= out_valid_d;
      out_byte  <= out_byte_d;
      out_last  <= out_last_d;
      err       <= err_d;
      if (load) begin
        rex_q      <= c_rex;
        wrxb_q     <= rex_wrxb;
        opc_sz_q   <= c_opc_sz;
        opcode_q   <= opcode;
        modrm_en_q <= c_modrm;
        modrm_q    <= modrm;
        sib_en_q   <= c_sib;
        sib_q      <= sib;
        disp_sz_q  <= c_disp_sz;
        disp_q     <= disp;
        imm_sz_q   <= c_imm_sz;
        imm_q      <= imm;
      end
    end
  end

endmodule

// File: tb/tb_insn_byte_encoder.sv
// Directed bench for insn_byte_encoder: table of bundles with expected byte
// streams, plus backpressure and mid-instruction reset sequences.
module tb_insn_byte_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic        rex_en;
  logic [3:0]  rex_wrxb;
  logic [1:0]  opc_len;
  logic [23:0] opcode;
  logic        has_modrm;
  logic [7:0]  modrm;
  logic        has_sib;
  logic [7:0]  sib;
  logic [1:0]  disp_code;
  logic [31:0] disp;
  logic [2:0]  imm_code;
  logic [63:0] imm;
  logic        out_valid, out_ready, out_last, err;
  logic [7:0]  out_byte;

  always #5 clk = ~clk;

  insn_byte_encoder #(.MAX_LEN(15)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rex_en(rex_en), .rex_wrxb(rex_wrxb), .opc_len(opc_len), .opcode(opcode),
    .has_modrm(has_modrm), .modrm(modrm), .has_sib(has_sib), .sib(sib),
    .disp_code(disp_code), .disp(disp), .imm_code(imm_code), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_last(out_last), .err(err)
  );

  // Expected bytes are right-aligned in emission order: first byte most significant.
  typedef struct packed {
    logic        rex_en;
    logic [3:0]  wrxb;
    logic [1:0]  opc_len;
    logic [23:0] opcode;
    logic        has_modrm;
    logic [7:0]  modrm;
    logic        has_sib;
    logic [7:0]  sib;
    logic [1:0]  disp_code;
    logic [31:0] disp;
    logic [2:0]  imm_code;
    logic [63:0] imm;
    logic [4:0]  len;
    logic [143:0] bytes;
    logic        rej;
  } vec_t;

`ifdef INSN_ENCODER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic apply(input vec_t v);
    rex_en = v.rex_en;  rex_wrxb = v.wrxb;  opc_len = v.opc_len;  opcode = v.opcode;
    has_modrm = v.has_modrm;  modrm = v.modrm;  has_sib = v.has_sib;  sib = v.sib;
    disp_code = v.disp_code;  disp = v.disp;  imm_code = v.imm_code;  imm = v.imm;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the last byte.
  task automatic run_vec(input vec_t v, input int id);
    logic [143:0] sh;
    check($sformatf("v%0d in_ready before", id), in_ready, 1'b1);
    apply(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    if (v.rej) begin
      check($sformatf("v%0d err pulse", id), err, 1'b1);
      check($sformatf("v%0d no valid on err", id), out_valid, 1'b0);
      @(negedge clk);
      check($sformatf("v%0d err cleared", id), err, 1'b0);
      check($sformatf("v%0d no valid after err", id), out_valid, 1'b0);
      check($sformatf("v%0d in_ready after err", id), in_ready, 1'b1);
    end else begin
      check($sformatf("v%0d err low", id), err, 1'b0);
      for (int i = 0; i < int'(v.len); i++) begin
        sh = v.bytes >> (8 * (int'(v.len) - 1 - i));
        check($sformatf("v%0d valid%0d", id, i), out_valid, 1'b1);
        check($sformatf("v%0d byte%0d", id, i), out_byte, sh[7:0]);
        check($sformatf("v%0d last%0d", id, i), out_last, (i == int'(v.len) - 1));
        check($sformatf("v%0d in_ready busy%0d", id, i), in_ready, 1'b0);
        @(negedge clk);
      end
      check($sformatf("v%0d valid after last", id), out_valid, 1'b0);
      check($sformatf("v%0d in_ready after last", id), in_ready, 1'b1);
    end
  endtask

  vec_t vecs [8];
  logic       bp_rdy [5];
  logic [7:0] bp_byte [5];
  logic       bp_last [5];

  initial begin
    vecs[0] = '{1'b1, 4'b1000, 2'd1, 24'h000089, 1'b1, 8'hC3, 1'b0, 8'h00, 2'd0, 32'h0,
                3'd0, 64'h0, 5'd3, 144'h4889C3, 1'b0};
    vecs[1] = '{1'b0, 4'b0000, 2'd1, 24'h0000C7, 1'b1, 8'h84, 1'b1, 8'h24, 2'd2, 32'h12345678,
                3'd3, 64'hDEADBEEF, 5'd11, 144'hC7842478563412EFBEADDE, 1'b0};
    vecs[2] = '{1'b0, 4'b0000, 2'd3, 24'h0F38F0, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 32'h0,
                3'd0, 64'h0, 5'd3, 144'h0F38F0, 1'b0};
    vecs[3] = '{1'b1, 4'b0001, 2'd1, 24'hFFFFB8, 1'b0, 8'h55, 1'b1, 8'h99, 2'd1, 32'hFFFFFFAB,
                3'd2, 64'hFFFFFFFFFFFF1234, 5'd5, 144'h41B8AB3412, 1'b0};
    vecs[4] = '{1'b1, 4'b1000, 2'd1, 24'h0000B8, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 32'h0,
                3'd4, 64'h1122334455667788, 5'd10, 144'h48B88877665544332211, 1'b0};
    vecs[5] = '{1'b1, 4'b1000, 2'd1, 24'h0000C7, 1'b1, 8'h80, 1'b0, 8'h00, 2'd2, 32'h12345678,
                3'd4, 64'h1122334455667788, 5'd15, 144'h48C780785634128877665544332211, 1'b0};
    vecs[6] = '{1'b0, 4'b0000, 2'd0, 24'hAAAA90, 1'b0, 8'h00, 1'b0, 8'h00, 2'd3, 32'h04030201,
                3'd7, 64'h0807060504030201, 5'd13, 144'h90010203040102030405060708, CHK};
    vecs[7] = '{1'b1, 4'b1000, 2'd3, 24'h0F38F0, 1'b1, 8'h84, 1'b1, 8'h24, 2'd2, 32'h12345678,
                3'd4, 64'h1122334455667788, 5'd18,
                144'h480F38F08424785634128877665544332211, CHK};

    bp_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bp_byte = '{8'h48, 8'h89, 8'h89, 8'h89, 8'hC3};
    bp_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1;  in_valid = 1'b0;  out_ready = 1'b1;
    apply(vecs[0]);
    #1;
    check("rst out_valid", out_valid, 1'b0);
    check("rst out_byte", out_byte, 8'h00);
    check("rst out_last", out_last, 1'b0);
    check("rst err", err, 1'b0);
    check("rst in_ready", in_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

    // Backpressure on mov rbx,rax: ready pattern 1,0,0,1,1 after first valid.
    apply(vecs[0]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      out_ready = bp_rdy[k];
      check($sformatf("bp valid%0d", k), out_valid, 1'b1);
      check($sformatf("bp byte%0d", k), out_byte, bp_byte[k]);
      check($sformatf("bp last%0d", k), out_last, bp_last[k]);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("bp valid after 5 cycles", out_valid, 1'b0);
    check("bp in_ready", in_ready, 1'b1);

    // Reset after two of eleven bytes, then a fresh bundle from its first byte.
    apply(vecs[1]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("mr byte0", out_byte, 8'hC7);
    @(negedge clk);
    check("mr byte1", out_byte, 8'h84);
    @(negedge clk);
    check("mr byte2 pending", out_byte, 8'h24);
    #2 reset = 1'b1;
    #1;
    check("mr async valid drop", out_valid, 1'b0);
    check("mr async last", out_last, 1'b0);
    check("mr in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    run_vec(vecs[2], 20);
    run_vec(vecs[0], 21);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
